// File: rtl/ring_para_rx.sv
// Receive end of the para ring: timestamps each hit and queues it
// in a FIFO that the host register block drains one entry at a time.
module ring_para_rx #(
  parameter int AW   = 4,
  parameter int TS_W = 16
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic [15:0]      ph_ring,
  input  logic             ph_vld,
  input  logic             clr,
  input  logic             rd_req,
  output logic [TS_W+15:0] rd_data,
  output logic             rd_vld,
  output logic [AW:0]      stu_level,
  output logic             stu_empty,
  output logic             stu_full,
  output logic [15:0]      stu_ovf,
  output logic [15:0]      stu_hits,
  output logic [15:0]      stu_last_ring
);

  localparam int DEPTH = 1 << AW;
  localparam int EW    = TS_W + 16;
  localparam logic [AW:0] LVL_MAX = DEPTH[AW:0];
  localparam logic [AW:0] LVL_ONE = (AW+1)'(1);

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     level;
  logic [TS_W-1:0] ts_cnt;
  logic            empty;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  assign empty = (level == '0);
  assign full  = (level == LVL_MAX);

  // A pop from a full FIFO frees the slot the same-cycle hit lands in.
  assign pop  = rd_req & ~empty & ~clr;
  assign push = ph_vld & (~full | pop) & ~clr;
  assign drop = ph_vld & full & ~pop & ~clr;

  assign stu_level = level;
  assign stu_empty = empty;
  assign stu_full  = full;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= '0;
    end else if (clr) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_W'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case (1'b1)
        push & ~pop: level <= level + LVL_ONE;
        pop & ~push: level <= level - LVL_ONE;
        default:     level <= level;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= {ts_cnt, ph_ring};
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
      rd_vld  <= 1'b0;
    end else begin
      rd_vld <= pop;
      if (pop) rd_data <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      stu_ovf       <= '0;
      stu_hits      <= '0;
      stu_last_ring <= '0;
    end else if (clr) begin
      stu_ovf       <= '0;
      stu_hits      <= '0;
      stu_last_ring <= '0;
    end else begin
      if (push) begin
        stu_hits      <= stu_hits + 16'd1;
        stu_last_ring <= ph_ring;
      end
      if (drop && stu_ovf != 16'hFFFF) stu_ovf <= stu_ovf + 16'd1;
    end
  end

endmodule

// File: tb/tb_ring_para_rx.sv
// Randomised and directed bench for ring_para_rx against a
// queue-based model of the hit FIFO.
module tb_ring_para_rx;

  logic        clk_sys = 1'b0;
  logic        rst_n   = 1'b0;
  logic [15:0] ph_ring = '0;
  logic        ph_vld  = 1'b0;
  logic        clr     = 1'b0;
  logic        rd_req  = 1'b0;
  logic [31:0] rd_data;
  logic        rd_vld;
  logic [4:0]  stu_level;
  logic        stu_empty;
  logic        stu_full;
  logic [15:0] stu_ovf;
  logic [15:0] stu_hits;
  logic [15:0] stu_last_ring;

  ring_para_rx #(.AW(4), .TS_W(16)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .ph_ring(ph_ring), .ph_vld(ph_vld),
    .clr(clr), .rd_req(rd_req),
    .rd_data(rd_data), .rd_vld(rd_vld),
    .stu_level(stu_level), .stu_empty(stu_empty),
    .stu_full(stu_full), .stu_ovf(stu_ovf),
    .stu_hits(stu_hits), .stu_last_ring(stu_last_ring)
  );

  always #5 clk_sys = ~clk_sys;

  logic [31:0] q[$];
  logic [15:0] m_ts;
  logic [15:0] m_ovf;
  logic [15:0] m_hits;
  logic [15:0] m_last;
  logic        m_vld;
  logic [31:0] m_data;
  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ts = 0; m_ovf = 0; m_hits = 0; m_last = 0;
    m_vld = 0; m_data = 0;
  endtask

  task automatic check_all();
    chk("rd_vld", 32'(rd_vld), 32'(m_vld));
    chk("rd_data", rd_data, m_data);
    chk("level", 32'(stu_level), 32'(q.size()));
    chk("empty", 32'(stu_empty), 32'(q.size() == 0));
    chk("full", 32'(stu_full), 32'(q.size() == 16));
    chk("ovf", 32'(stu_ovf), 32'(m_ovf));
    chk("hits", 32'(stu_hits), 32'(m_hits));
    chk("last", 32'(stu_last_ring), 32'(m_last));
  endtask

  task automatic cycle(input logic v, input logic [15:0] r,
                       input logic rq, input logic c, input bit do_chk);
    bit p;
    ph_vld = v; ph_ring = r; rd_req = rq; clr = c;
    @(posedge clk_sys);
    if (c) begin
      q.delete();
      m_ts = 0; m_ovf = 0; m_hits = 0; m_last = 0; m_vld = 0;
    end else begin
      p = rq && q.size() > 0;
      m_vld = p;
      if (p) m_data = q.pop_front();
      if (v) begin
        if (q.size() < 16) begin
          q.push_back({m_ts, r});
          m_hits = m_hits + 16'd1;
          m_last = r;
        end else if (m_ovf != 16'hFFFF) begin
          m_ovf = m_ovf + 16'd1;
        end
      end
      m_ts = m_ts + 16'd1;
    end
    #1;
    if (do_chk) check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 16'h0, 0, 0, 1);
  endtask

  logic [15:0] sv_ovf;

  initial begin
    model_reset();
    #12;
    check_all();
    chk("rst_empty", 32'(stu_empty), 32'd1);
    @(negedge clk_sys);
    rst_n = 1'b1;

    // first hit lands at timestamp 10
    idle(10);
    cycle(1, 16'h0005, 0, 0, 1);
    chk("t1_level", 32'(stu_level), 32'd1);
    chk("t1_last", 32'(stu_last_ring), 32'h5);
    cycle(0, 16'h0, 1, 0, 1);
    chk("t1_vld", 32'(rd_vld), 32'd1);
    chk("t1_data", rd_data, 32'h000A_0005);

    cycle(0, 16'h0, 0, 1, 1);
    for (int i = 1; i <= 16; i++) cycle(1, 16'(i), 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(1, 16'(100 + i), 0, 0, 1);
    chk("t2_full", 32'(stu_full), 32'd1);
    chk("t2_ovf", 32'(stu_ovf), 32'd3);
    chk("t2_hits", 32'(stu_hits), 32'd16);
    for (int i = 1; i <= 16; i++) begin
      cycle(0, 16'h0, 1, 0, 1);
      chk("t2_ring", 32'(rd_data[15:0]), 32'(i));
    end
    chk("t2_empty", 32'(stu_empty), 32'd1);

    for (int i = 0; i < 5; i++) begin
      cycle(0, 16'h0, 1, 0, 1);
      chk("t3_vld", 32'(rd_vld), 32'd0);
      chk("t3_level", 32'(stu_level), 32'd0);
    end

    for (int i = 1; i <= 16; i++) cycle(1, 16'(i), 0, 0, 1);
    sv_ovf = stu_ovf;
    cycle(1, 16'hBEEF, 1, 0, 1);
    chk("t4_vld", 32'(rd_vld), 32'd1);
    chk("t4_ring", 32'(rd_data[15:0]), 32'd1);
    chk("t4_level", 32'(stu_level), 32'd16);
    chk("t4_ovf", 32'(stu_ovf), 32'(sv_ovf));
    for (int i = 0; i < 16; i++) cycle(0, 16'h0, 1, 0, 1);
    chk("t4_tail", 32'(rd_data[15:0]), 32'hBEEF);
    cycle(1, 16'h1234, 1, 0, 1);
    chk("t4e_level", 32'(stu_level), 32'd1);
    chk("t4e_vld", 32'(rd_vld), 32'd0);
    cycle(0, 16'h0, 1, 0, 1);

    cycle(0, 16'h0, 0, 1, 1);
    for (int i = 0; i < 20; i++) cycle(1, 16'(i + 50), 0, 0, 1);
    chk("t5_ovf4", 32'(stu_ovf), 32'd4);
    cycle(1, 16'hDEAD, 0, 1, 1);
    chk("t5_level", 32'(stu_level), 32'd0);
    chk("t5_ovf", 32'(stu_ovf), 32'd0);
    chk("t5_hits", 32'(stu_hits), 32'd0);
    chk("t5_vld", 32'(rd_vld), 32'd0);
    cycle(1, 16'h0077, 0, 0, 1);
    cycle(0, 16'h0, 1, 0, 1);
    chk("t5_ts0", rd_data, 32'h0000_0077);

    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 3) != 0, 16'($urandom),
            ($urandom % 5) < 2, ($urandom % 97) == 0, 1);
    end

    cycle(0, 16'h0, 0, 1, 1);
    for (int i = 0; i < 16; i++) cycle(1, 16'(i), 0, 0, 1);
    for (int i = 0; i < 65534; i++) cycle(1, 16'h0, 0, 0, 0);
    check_all();
    chk("t6_fffe", 32'(stu_ovf), 32'hFFFE);
    for (int i = 0; i < 3; i++) cycle(1, 16'h0, 0, 0, 1);
    chk("t6_sat", 32'(stu_ovf), 32'hFFFF);

    for (int i = 0; i < 8; i++) cycle(1, 16'($urandom), 1, 0, 1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("t6_rst_empty", 32'(stu_empty), 32'd1);
    chk("t6_rst_data", rd_data, 32'd0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cycle(($urandom % 2) != 0, 16'($urandom),
            ($urandom % 2) != 0, 1'b0, 1);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
